// File: rtl/reset_request_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reset_req_pkg
//   Shared types and constants for the fabric reset request controller.
//   - state_t      : controller FSM states
//   - CAUSE_*      : bit positions of the request sources in REQ / CAUSE
//   - max3()       : helper used to size the shared down-counter
// ---------------------------------------------------------------------------
package reset_req_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSERT   = 3'd1,
        WAIT_ACK = 3'd2,
        RELEASE  = 3'd3,
        HOLDOFF  = 3'd4
    } state_t;

    localparam int CAUSE_SW   = 0;
    localparam int CAUSE_WDOG = 1;
    localparam int CAUSE_PLL  = 2;
    localparam int CAUSE_DBG  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_request_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer with asynchronous active-low reset to RESET_VAL.
//   Ports:
//     i_clk   : destination clock
//     i_rst_n : asynchronous active-low reset
//     i_d     : asynchronous input
//     o_q     : synchronized output (2-cycle latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_request_ctrl.sv
// ---------------------------------------------------------------------------
// reset_request_ctrl
//   Initiator side of the fabric reset path. Collects level-sensitive reset
//   requests, drives CORERESET_PF EXT_RST_N, checks that FABRIC_RESET_N
//   asserts and releases in response, and keeps a cause record that lives in
//   the always-on domain (never reset by FABRIC_RESET_N).
//
//   Handshake: EXT_RST_N low is the request, FABRIC_RESET_N (synchronized to
//   ack_n) low is the acknowledge. The request is held low for at least
//   ASSERT_CYCLES and until ack_n is seen low (or ACK_TIMEOUT expires); after
//   EXT_RST_N returns high the block waits for ack_n high (or ACK_TIMEOUT),
//   then stays busy for HOLDOFF_CYCLES before taking new requests.
//
//   Ports:
//     CLK            : system clock shared with CORERESET_PF
//     RESET_N        : asynchronous active-low reset (POR / INIT_DONE)
//     REQ            : level reset requests, one bit per source
//     REQ_MASK       : 1 masks the corresponding request
//     FABRIC_RESET_N : CORERESET_PF fabric reset, used as acknowledge
//     CAUSE_CLR      : pulse, clears CAUSE and TIMEOUT_ERR
//     EXT_RST_N      : registered reset request to CORERESET_PF
//     BUSY           : high whenever the FSM is not in IDLE
//     CAUSE          : sticky request bits of the last reset event
//     TIMEOUT_ERR    : sticky, set when an acknowledge edge times out
//     RST_COUNT      : reset events seen, saturating at 255
//     DBG_STATE      : current FSM state for observation
// ---------------------------------------------------------------------------
module reset_request_ctrl
    import reset_req_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ASSERT_CYCLES  = 16,
    parameter int ACK_TIMEOUT    = 256,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] REQ_MASK,
    input  logic               FABRIC_RESET_N,
    input  logic               CAUSE_CLR,
    output logic               EXT_RST_N,
    output logic               BUSY,
    output logic [NUM_REQ-1:0] CAUSE,
    output logic               TIMEOUT_ERR,
    output logic [7:0]         RST_COUNT,
    output state_t             DBG_STATE
);

    localparam int CNT_W = $clog2(max3(ASSERT_CYCLES, ACK_TIMEOUT, HOLDOFF_CYCLES)) + 1;

    // Counter load values: a state loaded with N-1 lasts exactly N cycles,
    // leaving on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] LD_ASSERT  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_ACK     = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_HOLDOFF = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ack_seen;
    logic               r_ext_rst_n;
    logic [NUM_REQ-1:0] r_cause;
    logic               r_timeout_err;
    logic [7:0]         r_rst_count;

    state_t             w_next_state;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ack_seen_next;
    logic               w_timeout_set;
    logic               w_capture;
    logic               w_merge;
    logic               w_ack_n;
    logic [NUM_REQ-1:0] w_hit;
    logic               w_cnt_zero;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_ack_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (FABRIC_RESET_N),
        .o_q     (w_ack_n)
    );

    assign w_hit      = REQ & ~REQ_MASK;
    assign w_cnt_zero = (r_cnt == '0);

    // -----------------------------------------------------------------------
    // Next-state / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_cnt_next      = r_cnt;
        w_ack_seen_next = r_ack_seen;
        w_timeout_set   = 1'b0;
        w_capture       = 1'b0;
        w_merge         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_hit != '0) begin
                    w_capture       = 1'b1;
                    w_ack_seen_next = 1'b0;
                    w_cnt_next      = LD_ASSERT;
                    w_next_state    = ASSERT;
                end
            end

            ASSERT: begin
                w_merge = 1'b1;
                if (!w_ack_n) begin
                    w_ack_seen_next = 1'b1;
                end
                if (w_cnt_zero) begin
                    w_cnt_next = LD_ACK;
                    // An acknowledge arriving on the final cycle still counts.
                    if (r_ack_seen || !w_ack_n) begin
                        w_next_state = RELEASE;
                    end else begin
                        w_next_state = WAIT_ACK;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            WAIT_ACK: begin
                w_merge = 1'b1;
                if (!w_ack_n) begin
                    w_cnt_next   = LD_ACK;
                    w_next_state = RELEASE;
                end else if (w_cnt_zero) begin
                    w_timeout_set = 1'b1;
                    w_cnt_next    = LD_ACK;
                    w_next_state  = RELEASE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            RELEASE: begin
                if (w_ack_n) begin
                    w_cnt_next   = LD_HOLDOFF;
                    w_next_state = HOLDOFF;
                end else if (w_cnt_zero) begin
                    w_timeout_set = 1'b1;
                    w_cnt_next    = LD_HOLDOFF;
                    w_next_state  = HOLDOFF;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            HOLDOFF: begin
                if (w_cnt_zero) begin
                    w_next_state = IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM, counter and registered request output
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ack_seen  <= 1'b0;
            r_ext_rst_n <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_ack_seen  <= w_ack_seen_next;
            // Registered from the next state so the pin changes on the same
            // edge the FSM enters/leaves the request-low states.
            r_ext_rst_n <= !((w_next_state == ASSERT) || (w_next_state == WAIT_ACK));
        end
    end

    // -----------------------------------------------------------------------
    // Sticky status
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cause       <= '0;
            r_timeout_err <= 1'b0;
            r_rst_count   <= 8'd0;
        end else begin
            // A capture in IDLE takes priority over a simultaneous clear; a
            // clear during a merge wipes the old record before the current
            // hit is OR'ed in.
            if (w_capture) begin
                r_cause <= w_hit;
            end else if (w_merge) begin
                r_cause <= (CAUSE_CLR ? '0 : r_cause) | w_hit;
            end else if (CAUSE_CLR) begin
                r_cause <= '0;
            end

            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (CAUSE_CLR) begin
                r_timeout_err <= 1'b0;
            end

            if (w_capture && (r_rst_count != 8'hFF)) begin
                r_rst_count <= r_rst_count + 8'd1;
            end
        end
    end

    assign EXT_RST_N   = r_ext_rst_n;
    assign BUSY        = (r_state != IDLE);
    assign CAUSE       = r_cause;
    assign TIMEOUT_ERR = r_timeout_err;
    assign RST_COUNT   = r_rst_count;
    assign DBG_STATE   = r_state;

endmodule
